// File: rtl/reaction_pkg.sv
// Package: reaction_pkg
// Shared state encodings for the reaction-time session controller.
// The 3-bit values are fixed because the display/debug path decodes them.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WAIT  = 3'd2,
    GO    = 3'd3,
    FOUL  = 3'd4,
    STORE = 3'd5,
    NEXT  = 3'd6,
    DONE  = 3'd7
  } stateT;

endpackage

// File: rtl/reaction_session_ctrl_edge_detect.sv
// Module: edge_detect
// Rising-edge pulse generator for an already debounced, synchronous level.
// Ports:
//   Clock  - rising-edge clock
//   reset  - asynchronous, active-high reset (clears the history bit)
//   level  - input level
//   pulse  - high for the cycle in which level is 1 and was 0 last cycle
module edge_detect (
  input  logic Clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic levelPrev;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) levelPrev <= 1'b0;
    else       levelPrev <= level;
  end

  // A button still held from an earlier phase has levelPrev=1 and never fires.
  assign pulse = level & ~levelPrev;

endmodule

// File: rtl/reaction_session_ctrl.sv
// Module: reaction_session_ctrl
// Multi-round reaction-time game sequencer. Each round runs a red wait,
// a green go phase and hit capture, then writes the score into the next
// register-file slot. It also detects false starts and misses, and it
// tracks the best (lowest) non-foul score.
// Ports:
//   Clock, buttonReset                  - clock, async active-high reset
//   buttonStart, buttonHit              - debounced buttons (rising edge acts)
//   delayCounterDone, scoreCounter      - external delay / reaction counters
//   RedLed, ledGreen, ledFoul           - indicators
//   delayCounterClear/Enable            - delay counter control
//   scoreCounterClear/Enable            - score counter control
//   registerLoad, registerLoadData,
//   WriteAddress                        - register-file write port
//   roundIndex, bestScore, sessionDone  - session status
//
// state | meaning
// IDLE  | between rounds, waiting for start
// ARM   | clear delay and score counters
// WAIT  | red LED, random delay running
// GO    | green LED, reaction count running
// FOUL  | hit seen during red wait
// STORE | write captured score, update best
// NEXT  | advance round or finish session
// DONE  | session complete, start begins a new one
module reaction_session_ctrl
  import reaction_pkg::*;
#(
  parameter int                 SCORE_W    = 13,
  parameter int                 ADDR_W     = 3,
  parameter int                 ROUNDS     = 4,
  parameter int                 BASE_ADDR  = 1,
  parameter logic [SCORE_W-1:0] MAX_SCORE  = 13'h1FFF,
  parameter logic [SCORE_W-1:0] FOUL_SCORE = 13'h1FFE
) (
  input  logic               Clock,
  input  logic               buttonReset,
  input  logic               buttonStart,
  input  logic               buttonHit,
  input  logic               delayCounterDone,
  input  logic [SCORE_W-1:0] scoreCounter,
  output logic               RedLed,
  output logic               ledGreen,
  output logic               ledFoul,
  output logic               delayCounterClear,
  output logic               delayCounterEnable,
  output logic               scoreCounterClear,
  output logic               scoreCounterEnable,
  output logic               registerLoad,
  output logic [SCORE_W-1:0] registerLoadData,
  output logic [ADDR_W-1:0]  WriteAddress,
  output logic [ADDR_W-1:0]  roundIndex,
  output logic [SCORE_W-1:0] bestScore,
  output logic               sessionDone
);

  logic               startEdge;
  logic               hitEdge;
  stateT              state;
  logic [SCORE_W-1:0] captured;
  logic [ADDR_W-1:0]  writeAddr;
  logic [ADDR_W-1:0]  slotAddr;

  edge_detect uStartEdge (
    .Clock (Clock),
    .reset (buttonReset),
    .level (buttonStart),
    .pulse (startEdge)
  );

  edge_detect uHitEdge (
    .Clock (Clock),
    .reset (buttonReset),
    .level (buttonHit),
    .pulse (hitEdge)
  );

  assign slotAddr = ADDR_W'(BASE_ADDR) + roundIndex;

  always_ff @(posedge Clock or posedge buttonReset) begin
    if (buttonReset) begin
      state      <= IDLE;
      roundIndex <= '0;
      bestScore  <= '1;
      captured   <= '0;
      writeAddr  <= '0;
    end else begin
      case (state)
        IDLE: if (startEdge) state <= ARM;
        ARM:  state <= WAIT;
        WAIT: begin
          // A hit always wins over delay expiry in the same cycle.
          if (hitEdge) begin
            captured  <= FOUL_SCORE;
            writeAddr <= slotAddr;
            state     <= FOUL;
          end else if (delayCounterDone) begin
            state <= GO;
          end
        end
        GO: begin
          if (hitEdge) begin
            captured  <= scoreCounter;
            writeAddr <= slotAddr;
            state     <= STORE;
          end else if (scoreCounter == MAX_SCORE) begin
            captured  <= MAX_SCORE;
            writeAddr <= slotAddr;
            state     <= STORE;
          end
        end
        FOUL: state <= STORE;
        STORE: begin
          if (captured != FOUL_SCORE && captured < bestScore) bestScore <= captured;
          state <= NEXT;
        end
        NEXT: begin
          if (roundIndex == ADDR_W'(ROUNDS - 1)) begin
            state <= DONE;
          end else begin
            roundIndex <= roundIndex + 1'b1;
            state      <= IDLE;
          end
        end
        DONE: begin
          if (startEdge) begin
            roundIndex <= '0;
            bestScore  <= '1;
            state      <= ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the state register. Outputs drop as soon as reset
  // forces the state back to IDLE.
  always_comb begin
    RedLed             = 1'b0;
    ledGreen           = 1'b0;
    ledFoul            = 1'b0;
    delayCounterClear  = 1'b0;
    delayCounterEnable = 1'b0;
    scoreCounterClear  = 1'b0;
    scoreCounterEnable = 1'b0;
    registerLoad       = 1'b0;
    sessionDone        = 1'b0;
    case (state)
      ARM: begin
        delayCounterClear = 1'b1;
        scoreCounterClear = 1'b1;
      end
      WAIT: begin
        RedLed             = 1'b1;
        delayCounterEnable = 1'b1;
      end
      GO: begin
        ledGreen           = 1'b1;
        scoreCounterEnable = 1'b1;
      end
      FOUL:    ledFoul      = 1'b1;
      STORE:   registerLoad = 1'b1;
      DONE:    sessionDone  = 1'b1;
      default: ;
    endcase
  end

  assign registerLoadData = captured;
  assign WriteAddress     = writeAddr;

endmodule

// File: doc/reaction_session_ctrl.md
Name: reaction_session_ctrl

Overview:
Parametrised multi-round controller for the reaction-time game. It sequences ROUNDS trials of red wait, green go and hit capture. Each trial's score is written into consecutive register-file slots. It adds false-start detection, miss timeout and best-score tracking. It sits between the debounced buttons, the external delay and score counters, and the register file; the display path reads bestScore and sessionDone.

Parameters:
SCORE_W, 13, width of scoreCounter, captured score and bestScore
ADDR_W, 3, register-file address width
ROUNDS, 4, trials per session; legal range 1 .. 2**ADDR_W - BASE_ADDR
BASE_ADDR, 1, register-file slot for round 0
MAX_SCORE, 13'h1FFF, scoreCounter value treated as a miss (timeout)
FOUL_SCORE, 13'h1FFE, value stored for a false start

Ports:
Clock  in  1  rising-edge clock
buttonReset  in  1  asynchronous, active-high reset
buttonStart  in  1  debounced, synchronous level; acted on at rising edge
buttonHit  in  1  debounced, synchronous level; acted on at rising edge
delayCounterDone  in  1  random delay expired
scoreCounter  in  SCORE_W  elapsed reaction count
RedLed  out  1  wait indicator
ledGreen  out  1  go indicator
ledFoul  out  1  false-start indicator
delayCounterClear  out  1  synchronous clear of delay counter
delayCounterEnable  out  1  delay counter count enable
scoreCounterClear  out  1  synchronous clear of score counter
scoreCounterEnable  out  1  score counter count enable
registerLoad  out  1  register-file write strobe
registerLoadData  out  SCORE_W  write data
WriteAddress  out  ADDR_W  write address
roundIndex  out  ADDR_W  current round, 0 .. ROUNDS-1
bestScore  out  SCORE_W  minimum non-foul score this session
sessionDone  out  1  all rounds complete

Behaviour:
- Edge detect: startEdge = buttonStart & ~startPrev and hitEdge = buttonHit & ~hitPrev. startPrev and hitPrev are registered every cycle.
- All outputs are Moore outputs decoded from the state register, except registerLoadData, WriteAddress, roundIndex and bestScore, which come from datapath registers.
- Reset (asynchronous, active-high): state=IDLE, roundIndex=0, bestScore=all ones, captured=0, startPrev=hitPrev=0. Reset is honoured in any state, mid-round included, and all outputs are 0 except bestScore.
- IDLE: all strobes and LEDs 0. On startEdge, go to ARM.
- ARM (1 cycle): delayCounterClear=1 and scoreCounterClear=1. Go to WAIT.
- WAIT: RedLed=1, delayCounterEnable=1.
  - On hitEdge: captured=FOUL_SCORE, go to FOUL. hitEdge has priority over delayCounterDone in the same cycle.
  - Else on delayCounterDone: go to GO.
- GO: ledGreen=1, scoreCounterEnable=1.
  - On hitEdge: captured=scoreCounter as sampled in that cycle, go to STORE.
  - Else if scoreCounter==MAX_SCORE: captured=MAX_SCORE, go to STORE.
  - hitEdge and timeout together: hit wins.
- FOUL (1 cycle): ledFoul=1. Go to STORE.
- STORE (1 cycle): registerLoad=1, registerLoadData=captured, WriteAddress=BASE_ADDR+roundIndex (truncated to ADDR_W).
  - If captured != FOUL_SCORE and captured < bestScore (unsigned): bestScore<=captured.
  - Go to NEXT.
- NEXT (1 cycle):
  - If roundIndex==ROUNDS-1: go to DONE; roundIndex holds.
  - Else: roundIndex<=roundIndex+1, go to IDLE.
- DONE: sessionDone=1. On startEdge: roundIndex<=0, bestScore<=all ones, go to ARM.
- Latency:
  - hitEdge in GO -> registerLoad 1 cycle later.
  - hitEdge in WAIT -> registerLoad 2 cycles later.
- A button held from a previous phase never triggers. Only a fresh 0->1 transition counts.
- If a session is all fouls, bestScore stays all ones.
- Unused state encodings go to IDLE on the next clock.

Decomposition:
- Package reaction_pkg holds the state encodings: IDLE=0, ARM=1, WAIT=2, GO=3, FOUL=4, STORE=5, NEXT=6, DONE=7, as 3-bit constants.
- One sub-module, edge_detect: a registered rising-edge pulse with asynchronous reset, instantiated twice.

Test Plan:
1. Reset, startEdge, delayCounterDone after 10 cycles, hit with scoreCounter=250 -> registerLoad with data 250 at address 1; bestScore=250; roundIndex=1; state IDLE.
2. Hit during WAIT -> ledFoul for 1 cycle, then write 0x1FFE at address BASE_ADDR+roundIndex; bestScore unchanged.
3. In GO, drive scoreCounter to 0x1FFF with no hit -> write 0x1FFF; hit and timeout in the same cycle -> captured equals the scoreCounter value.
4. Four rounds with scores 300, 120, foul, 200 -> writes to addresses 1..4; bestScore=120; sessionDone=1; a new startEdge resets roundIndex to 0 and bestScore to 0x1FFF.
5. Assert buttonReset asynchronously mid-GO -> outputs drop immediately with no clock edge; state=IDLE; bestScore=0x1FFF.
6. Hold buttonHit high from IDLE through to GO -> no foul and no capture until release and re-press.
